// File: rtl/tick_timer_if.sv
// Control/status bundle between the timer and its controller.
interface tick_timer_if #(
  parameter int WIDTH = 4
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic             ack;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             pulse;
  logic             expired;
  logic             overrun;

  modport master (
    output tick, start, stop, mode, period, ack,
    input  busy, count, pulse, expired, overrun
  );

  modport slave (
    input  tick, start, stop, mode, period, ack,
    output busy, count, pulse, expired, overrun
  );
endinterface

// File: rtl/tick_timer.sv
// Programmable interval timer counting prescaler ticks up to a latched
// period; one-shot or periodic, with sticky expiry/overrun flags.
module tick_timer #(
  parameter int WIDTH = 4
) (
  input  logic        CLK,
  input  logic        ASYNCRESETN,
  tick_timer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic             expired_q, expired_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] last_cnt;

  // Final count value of an interval; period_q is never 0 while in RUN.
  assign last_cnt = period_q - WIDTH'(1);

  // Next-state and flag logic; priority STOP > START > TICK.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    mode_d    = mode_q;
    pulse_d   = 1'b0;
    // ACK clears both sticky flags unless an expiry below sets them again.
    expired_d = expired_q & ~bus.ack;
    overrun_d = overrun_q & ~bus.ack;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (!bus.stop && bus.start && bus.period != '0) begin
          period_d = bus.period;
          mode_d   = bus.mode;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          count_d = '0;
          state_d = IDLE;
        end else if (bus.start) begin
          // Restart swallows any tick on the same edge.
          count_d = '0;
          if (bus.period == '0) begin
            state_d = IDLE;
          end else begin
            period_d = bus.period;
            mode_d   = bus.mode;
          end
        end else if (bus.tick) begin
          if (count_q == last_cnt) begin
            count_d   = '0;
            pulse_d   = 1'b1;
            expired_d = 1'b1;
            if (expired_q && !bus.ack) overrun_d = 1'b1;
            if (!mode_q) state_d = IDLE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      mode_q    <= 1'b0;
      pulse_q   <= 1'b0;
      expired_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      pulse_q   <= pulse_d;
      expired_q <= expired_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.count   = count_q;
  assign bus.pulse   = pulse_q;
  assign bus.expired = expired_q;
  assign bus.overrun = overrun_q;

endmodule
